// File: rtl/gate_resp_misr.sv
// Response compactor: accepts VEC_COUNT words over valid/ready, folds them into a MISR
// and compares the final signature with exp_sig. Define RESP_XMASK_EN to add resp_mask.
module gate_resp_misr #(
  parameter int               RESP_W    = 5,
  parameter int               SIG_W     = 16,
  parameter int               VEC_COUNT = 512,
  parameter logic [SIG_W-1:0] POLY      = 16'h1021,
  parameter logic [SIG_W-1:0] SEED      = 16'h0000,
  localparam int              CNT_W     = $clog2(VEC_COUNT+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
`ifdef RESP_XMASK_EN
  input  logic [RESP_W-1:0] resp_mask,
`endif
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [SIG_W-1:0]   r_sig;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pass;
  logic               w_xfer, w_last, w_start;
  logic [RESP_W-1:0]  w_word;
  logic [SIG_W-1:0]   w_misr;

`ifdef RESP_XMASK_EN
  // Masked bits are forced to 0 so X/don't-care outputs cannot disturb the signature.
  assign w_word = resp_data & ~resp_mask;
`else
  assign w_word = resp_data;
`endif

  assign w_misr  = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(w_word);
  assign w_xfer  = resp_valid && (r_state == S_RUN);
  assign w_last  = w_xfer && (r_cnt == CNT_W'(VEC_COUNT-1));
  assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_CHECK;
      S_CHECK: w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig  <= SEED;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_sig  <= SEED;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_xfer) begin
      r_sig  <= w_misr;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else if (r_state == S_CHECK) begin
      r_pass <= (r_sig == exp_sig);
    end
  end

  // Handshake and status are pure decodes of the state register.
  always_comb begin
    resp_ready = (r_state == S_RUN);
    busy       = (r_state == S_RUN) || (r_state == S_CHECK);
    done       = (r_state == S_DONE);
  end

  assign pass      = r_pass;
  assign signature = r_sig;
  assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_gate_resp_misr.sv
// Randomized scoreboard bench for gate_resp_misr: a 512-word default instance and a
// one-word instance seeded at 0x8000 to exercise the feedback tap.
module tb_gate_resp_misr;
  localparam logic [15:0] POLY = 16'h1021;
  localparam int          NVEC = 512;

  logic        clk = 1'b0;
  logic        rst_n, start, resp_valid, resp_ready, busy, done, pass;
  logic [4:0]  resp_data, resp_mask;
  logic [15:0] exp_sig, signature;
  logic [9:0]  vec_cnt;

  logic        b_start, b_valid, b_ready, b_busy, b_done, b_pass;
  logic [4:0]  b_data, b_mask;
  logic [15:0] b_exp, b_sig;
  logic [0:0]  b_cnt;

  always #5 clk = ~clk;

  gate_resp_misr u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
`ifdef RESP_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .exp_sig(exp_sig), .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_cnt(vec_cnt)
  );

  gate_resp_misr #(.VEC_COUNT(1), .SEED(16'h8000)) u_one (
    .clk(clk), .rst_n(rst_n), .start(b_start), .resp_valid(b_valid), .resp_ready(b_ready),
    .resp_data(b_data),
`ifdef RESP_XMASK_EN
    .resp_mask(b_mask),
`endif
    .exp_sig(b_exp), .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_cnt(b_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic over GF(2): multiply by x, reduce, add the word.
  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [4:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(POLY);
    return 16'(v) ^ {11'd0, d};
  endfunction

  typedef struct { logic [15:0] sig; logic [9:0] cnt; } exp_t;
  exp_t sb_q[$];
  bit   pass_q[$];

  // Monitor: compare after every observed transfer and on every rising done.
  logic m_xfer = 1'b0, m_done_d = 1'b0;
  int   m_since = 0;
  always @(posedge clk) begin
    m_xfer  <= resp_valid && resp_ready && rst_n;
    m_since <= (resp_valid && resp_ready && rst_n) ? 1 : m_since + 1;
  end
  always @(negedge clk) begin
    if (m_xfer) begin
      if (sb_q.size() == 0) check("unexpected_xfer", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("signature", signature, e.sig);
        check("vec_cnt", vec_cnt, e.cnt);
      end
    end
    if (done && !m_done_d) begin
      if (pass_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        check("pass", pass, pass_q.pop_front());
        check("done_latency", m_since, 2);
      end
    end
    m_done_d <= done;
  end

  task automatic run(input bit rnd, input bit good, input int abort_at);
    logic [15:0] sig;
    int cnt;
    bit v;
    logic [4:0] d, m;
    start = 1'b1; resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sig = 16'h0000; cnt = 0;
    check("start_sig", signature, 16'h0000);
    check("start_cnt", vec_cnt, 0);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_pass", pass, 0);
    while (cnt < NVEC) begin
      if (cnt == abort_at) begin
        resp_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_sig", signature, 16'h0000);
        check("abort_cnt", vec_cnt, 0);
        check("abort_ready", resp_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        return;
      end
      v = ($urandom_range(0, 3) != 0);
      d = rnd ? 5'($urandom) : 5'h1F;
`ifdef RESP_XMASK_EN
      m = 5'($urandom);
`else
      m = 5'h00;
`endif
      resp_valid = v; resp_data = d; resp_mask = m;
      check("ready_run", resp_ready, 1);
      @(posedge clk);
      if (v) begin
        sig = mstep(sig, d & ~m);
        cnt++;
        sb_q.push_back('{sig, 10'(cnt)});
      end
      @(negedge clk);
    end
    exp_sig = good ? sig : sig ^ 16'($urandom_range(1, 65535));
    pass_q.push_back(good);
    resp_valid = 1'b1; resp_data = 5'($urandom);
    for (int i = 0; i < 3; i++) begin
      check("ready_after_last", resp_ready, 0);
      check("cnt_saturated", vec_cnt, NVEC);
      @(negedge clk);
    end
    resp_valid = 1'b0;
    check("done_held", done, 1);
    check("pass_held", pass, good);
    check("sig_held", signature, sig);
  endtask

  task automatic one_word(input logic [4:0] d, input logic [4:0] m, input bit good);
    logic [15:0] e;
    e = mstep(16'h8000, d & ~m);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("one_seed", b_sig, 16'h8000);
    check("one_ready", b_ready, 1);
    b_valid = 1'b1; b_data = d; b_mask = m;
    @(negedge clk);
    b_valid = 1'b0;
    check("one_sig", b_sig, e);
    check("one_cnt", b_cnt, 1);
    check("one_check_ready", b_ready, 0);
    check("one_check_done", b_done, 0);
    b_exp = good ? e : e ^ 16'h0001;
    @(negedge clk);
    check("one_done", b_done, 1);
    check("one_pass", b_pass, good);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; resp_valid = 1'b1; resp_data = 5'h1F; resp_mask = 5'h00; exp_sig = '0;
    b_start = 1'b1; b_valid = 1'b1; b_data = 5'h00; b_mask = 5'h00; b_exp = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", resp_ready, 0);
    check("rst_sig", signature, 16'h0000);
    check("rst_cnt", vec_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_one_sig", b_sig, 16'h8000);
    rst_n = 1'b1; start = 1'b0; resp_valid = 1'b0; b_start = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", resp_ready, 0);
    run(1'b0, 1'b1, -1);
    run(1'b1, 1'b1, -1);
    run(1'b1, 1'b0, -1);
    run(1'b1, 1'b1, 300);
    run(1'b1, 1'b1, -1);
    one_word(5'h00, 5'h00, 1'b1);
    one_word(5'h00, 5'h00, 1'b0);
`ifdef RESP_XMASK_EN
    one_word(5'h1F, 5'h1E, 1'b1);
`endif
    one_word(5'($urandom), 5'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("pass_q_drained", pass_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
